sram_bank_arbiter: RTL and testbench
====================================

SRAM_BANK_ARBITER -- requirements
Module: sram_bank_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 13, word address width of the shared 32 KB four-bank SRAM.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width of both requesters and the SRAM.
REQ-003 SHALL have parameter FIXED_PRIO, default 0; 0 selects round-robin, 1 means port 0 always wins.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-005 SHALL provide, per port p in {0,1}, the following signals.
- req_i[p] input 1: request.
- gnt_o[p] output 1: grant.
- addr_i[p] input ADDR_WIDTH: word address.
- we_i[p] input 1: write.
- be_i[p] input DATA_WIDTH/8: byte enables.
- wdata_i[p] input DATA_WIDTH: write data.
- rvalid_o[p] output 1: response valid.
- rdata_o[p] output DATA_WIDTH: read data.
REQ-006 SHALL provide the SRAM-side signals.
- en_o output 1: bank enable.
- addr_o output ADDR_WIDTH.
- we_o output 1.
- be_o output DATA_WIDTH/8.
- wdata_o output DATA_WIDTH.
- rdata_i input DATA_WIDTH: SRAM read data, valid one cycle after en_o.
REQ-007 SHALL provide the conflict-counter signals.
- clr_cnt_i input 1: synchronous clear of the conflict counter.
- conflict_cnt_o output 16: saturating count of cycles with both req_i high.

Function
REQ-008 SHALL compute gnt_o combinationally in the request cycle; at most one gnt_o bit is high per cycle; a lone request is always granted.
REQ-009 SHALL, when both ports request with FIXED_PRIO=0, grant the port other than last_grant; last_grant updates only on cycles where a grant is issued.
REQ-010 SHALL, when FIXED_PRIO=1, grant port 0 whenever req_i[0]=1.
REQ-011 SHALL, in a grant cycle, drive en_o=1 and pass addr/we/be/wdata of the granted port to the SRAM side unmodified.
REQ-012 SHALL, with no request, drive en_o=0, we_o=0, be_o=0, and addr_o/wdata_o from port 0.
REQ-013 SHALL assert rvalid_o[p] for exactly one cycle, exactly one cycle after gnt_o[p], for reads and writes alike; the response has no backpressure.
REQ-014 SHALL drive rdata_o[p]=rdata_i when rvalid_o[p]=1 for a read; rdata_o is don't-care otherwise and both ports may share the rdata_i wire.
REQ-015 SHALL support back-to-back grants every cycle, alternating ports under continuous contention: throughput 1 access per cycle.
REQ-016 SHALL not hold a request across cycles; an ungranted port keeps req_i high until granted.
REQ-017 SHALL increment conflict_cnt_o on each cycle with req_i[0]&req_i[1], saturating at 16'hFFFF.
REQ-018 SHALL give clr_cnt_i priority over increment; with both active the counter becomes 0.
REQ-019 SHALL ignore be_i on reads; the SRAM returns the full word.

Reset
REQ-020 SHALL, on rst_n low, asynchronously set rvalid_o=0, conflict_cnt_o=0 and last_grant=1, so port 0 wins the first conflict.
REQ-021 SHALL drop a response pending in the cycle reset is asserted; no rvalid_o is issued for it after reset release.
REQ-022 SHALL keep gnt_o and en_o low while rst_n is low, regardless of req_i.

Structure
REQ-023 SHALL place NUM_PORTS=2, the port index typedef and CNT_WIDTH=16 in shared package sram_arb_pkg.
REQ-024 SHALL implement grant selection in sub-module rr_arb_2: combinational grant plus the last_grant register.
REQ-025 SHALL keep the response pipeline (granted-port register, rvalid register) and the conflict counter in the top module.

Verification
REQ-026 SHALL cover single read: port 0 writes 32'hDEADBEEF at address 5, then reads address 5 -> gnt_o[0] in the request cycle, rvalid_o[0] one cycle later with rdata_o[0]=32'hDEADBEEF.
REQ-027 SHALL cover contention: both ports request continuously for 4 cycles after reset -> grant order 0,1,0,1 and conflict_cnt_o=4.
REQ-028 SHALL cover byte write: port 1 writes be=4'b0010, data 32'h0000AB00 to a word holding 32'h11223344 -> a later read returns 32'h1122AB44.
REQ-029 SHALL cover fixed priority: with FIXED_PRIO=1 and both ports requesting for 3 cycles -> gnt_o[0] all 3 cycles and port 1 is granted on the 4th cycle after req_i[0] drops.
REQ-030 SHALL cover reset mid-operation: rst_n asserted in the cycle after a grant -> no rvalid_o; counter=0; the first conflict after release is granted to port 0.
REQ-031 SHALL cover counter saturation and clear: the counter preloaded near saturation via forced contention stays at 16'hFFFF; clr_cnt_i with contention -> 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM bank arbiter.
package sram_arb_pkg;

  localparam int unsigned NUM_PORTS  = 2;
  localparam int unsigned PORT_IDX_W = 1;
  localparam int unsigned CNT_WIDTH  = 16;

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  // One-hot grant vector for a port index.
  function automatic logic [NUM_PORTS-1:0] port_onehot(input port_idx_t p);
    port_onehot    = '0;
    port_onehot[p] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_arb_2.sv
// Two-requester grant selection: combinational grant, registered last-grant.
module rr_arb_2
  import sram_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt_c,
  output port_idx_t            gnt_idx_c,
  output logic                 gnt_any_c
);

  port_idx_t last_grant_q;

  // Port 1 wins when alone, or on a conflict when port 0 had the last grant.
  always_comb begin
    gnt_idx_c = '0;
    gnt_c     = '0;
    if (req[1] && (!req[0] || (!FIXED_PRIO && (last_grant_q == port_idx_t'(0))))) begin
      gnt_idx_c = port_idx_t'(1);
    end
    if (rst_n && (|req)) begin
      gnt_c = port_onehot(gnt_idx_c);
    end
  end

  assign gnt_any_c = |gnt_c;

  // Reset to port 1 so port 0 takes the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= port_idx_t'(1);
    end else if (gnt_any_c) begin
      last_grant_q <= gnt_idx_c;
    end
  end

endmodule

// File: rtl/sram_bank_arbiter.sv
// Two-port arbiter in front of a single-ported SRAM bank with one-cycle read
// latency; tracks how many cycles both ports contended.
module sram_bank_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_PORTS-1:0]                    req_i,
  output logic [NUM_PORTS-1:0]                    gnt_o,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]    addr_i,
  input  logic [NUM_PORTS-1:0]                    we_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]  be_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    wdata_i,
  output logic [NUM_PORTS-1:0]                    rvalid_o,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    rdata_o,
  output logic                                    en_o,
  output logic [ADDR_WIDTH-1:0]                   addr_o,
  output logic                                    we_o,
  output logic [DATA_WIDTH/8-1:0]                 be_o,
  output logic [DATA_WIDTH-1:0]                   wdata_o,
  input  logic [DATA_WIDTH-1:0]                   rdata_i,
  input  logic                                    clr_cnt_i,
  output logic [CNT_WIDTH-1:0]                    conflict_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  port_idx_t            gnt_idx;
  logic                 gnt_any;
  logic                 rsp_valid_q;
  port_idx_t            rsp_port_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 conflict;

  rr_arb_2 #(
    .FIXED_PRIO (FIXED_PRIO != 0)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_i),
    .gnt_c     (gnt_o),
    .gnt_idx_c (gnt_idx),
    .gnt_any_c (gnt_any)
  );

  // SRAM request mux; idle cycles park on port 0 with strobes low.
  always_comb begin
    en_o    = 1'b0;
    we_o    = 1'b0;
    be_o    = '0;
    addr_o  = addr_i[0];
    wdata_o = wdata_i[0];
    if (gnt_any) begin
      en_o    = 1'b1;
      we_o    = we_i[gnt_idx];
      be_o    = be_i[gnt_idx];
      addr_o  = addr_i[gnt_idx];
      wdata_o = wdata_i[gnt_idx];
    end
  end

  // Response pipeline: remember who was granted, answer one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= '0;
    end else begin
      rsp_valid_q <= gnt_any;
      if (gnt_any) begin
        rsp_port_q <= gnt_idx;
      end
    end
  end

  // Read data is shared; only the addressed port sees rvalid.
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      rvalid_o[p] = rsp_valid_q && (rsp_port_q == port_idx_t'(p));
      rdata_o[p]  = rdata_i;
    end
  end

  assign conflict = &req_i;

  // Saturating contention counter; clear dominates increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_cnt_i) begin
      cnt_q <= '0;
    end else if (conflict && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Scoreboard bench for sram_bank_arbiter with a behavioural SRAM bank.
module tb_sram_bank_arbiter;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  typedef struct {
    int          port;
    bit          chk;
    logic [DW-1:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] req = '0;
  logic [1:0] fp_req = '0;
  logic [1:0][AW-1:0] addr = '0;
  logic [1:0] we = '0;
  logic [1:0][BW-1:0] be = '0;
  logic [1:0][DW-1:0] wdata = '0;
  logic clr = 1'b0;

  logic [1:0] gnt, rvalid, fp_gnt, fp_rvalid;
  logic [1:0][DW-1:0] rdata, fp_rdata;
  logic en, sram_we, fp_en, fp_we;
  logic [AW-1:0] sram_addr, fp_addr;
  logic [BW-1:0] sram_be, fp_be;
  logic [DW-1:0] sram_wdata, fp_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic [DW-1:0] fp_sram_rdata = '0;
  logic [15:0] cnt, fp_cnt;

  logic [DW-1:0] mem [0:63];

  logic [1:0] o_gnt, o_fp_gnt, o_rvalid, o_fp_rvalid;
  logic o_en, o_we;
  logic [AW-1:0] o_addr;
  logic [BW-1:0] o_be;
  logic [DW-1:0] o_wdata;
  logic [1:0][DW-1:0] o_rdata;
  logic [15:0] o_cnt;

  rsp_t exp_q[$];
  rsp_t rsp;
  int n_asserts = 0;
  int n_fail = 0;

  sram_bank_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .en_o(en),
    .addr_o(sram_addr), .we_o(sram_we), .be_o(sram_be), .wdata_o(sram_wdata),
    .rdata_i(sram_rdata), .clr_cnt_i(clr), .conflict_cnt_o(cnt)
  );

  sram_bank_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req_i(fp_req), .gnt_o(fp_gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(fp_rvalid), .rdata_o(fp_rdata), .en_o(fp_en),
    .addr_o(fp_addr), .we_o(fp_we), .be_o(fp_be), .wdata_o(fp_wdata),
    .rdata_i(fp_sram_rdata), .clr_cnt_i(clr), .conflict_cnt_o(fp_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: byte-masked writes, full-word reads one cycle later.
  always @(posedge clk) begin
    if (en) begin
      if (sram_we) begin
        for (int b = 0; b < BW; b++)
          if (sram_be[b]) mem[sram_addr[5:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr[5:0]];
      end
    end
  end

  // One cycle: sample grant side mid-cycle, response side just after the edge.
  task automatic tick();
    #3;
    o_gnt = gnt; o_fp_gnt = fp_gnt; o_en = en; o_we = sram_we;
    o_addr = sram_addr; o_be = sram_be; o_wdata = sram_wdata;
    @(posedge clk);
    #1;
    o_rvalid = rvalid; o_fp_rvalid = fp_rvalid; o_rdata = rdata; o_cnt = cnt;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; fp_req = '0; clr = 1'b0; we = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = 2'b11; fp_req = 2'b11;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_asserts++;
    if (gnt !== 2'b00 || fp_gnt !== 2'b00) begin
      n_fail++; $display("FAIL reset_gnt: got %b/%b expected 00/00", gnt, fp_gnt);
    end
    n_asserts++;
    if (en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", en); end
    n_asserts++;
    if (rvalid !== 2'b00 || cnt !== 16'h0) begin
      n_fail++; $display("FAIL reset_state: rvalid %b cnt %h expected 00 0000", rvalid, cnt);
    end
    rst_n = 1'b1; req = '0; fp_req = '0;
  endtask

  task automatic test_single_read();
    do_reset();
    req = 2'b01; addr[0] = 13'd5; we[0] = 1'b1; be[0] = 4'hF; wdata[0] = 32'hDEADBEEF;
    exp_q.push_back('{0, 1'b0, 32'h0});
    tick();
    n_asserts++;
    if (o_gnt !== 2'b01) begin n_fail++; $display("FAIL wr_gnt: got %b expected 01", o_gnt); end
    n_asserts++;
    if (o_en !== 1'b1 || o_we !== 1'b1 || o_addr !== 13'd5 || o_be !== 4'hF || o_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wr_sram: en %b we %b addr %0d be %h wdata %h expected 1 1 5 f deadbeef",
                         o_en, o_we, o_addr, o_be, o_wdata);
    end
    rsp = exp_q.pop_front();
    n_asserts++;
    if (o_rvalid !== (2'b01 << rsp.port)) begin
      n_fail++; $display("FAIL wr_rvalid: got %b expected %b", o_rvalid, 2'(2'b01 << rsp.port));
    end
    we[0] = 1'b0; be[0] = 4'h0;
    exp_q.push_back('{0, 1'b1, 32'hDEADBEEF});
    tick();
    n_asserts++;
    if (o_gnt !== 2'b01 || o_en !== 1'b1 || o_we !== 1'b0 || o_addr !== 13'd5) begin
      n_fail++; $display("FAIL rd_req: gnt %b en %b we %b addr %0d expected 01 1 0 5", o_gnt, o_en, o_we, o_addr);
    end
    rsp = exp_q.pop_front();
    n_asserts++;
    if (o_rvalid !== (2'b01 << rsp.port) || o_rdata[rsp.port] !== rsp.data) begin
      n_fail++; $display("FAIL rd_rsp: rvalid %b rdata %h expected %b %h", o_rvalid, o_rdata[rsp.port],
                         2'(2'b01 << rsp.port), rsp.data);
    end
    req = 2'b00; addr[0] = 13'd7; wdata[0] = 32'h12345678; we[0] = 1'b1; be[0] = 4'hF;
    tick();
    n_asserts++;
    if (o_gnt !== 2'b00 || o_en !== 1'b0 || o_we !== 1'b0 || o_be !== 4'h0 ||
        o_addr !== 13'd7 || o_wdata !== 32'h12345678) begin
      n_fail++; $display("FAIL idle_sram: gnt %b en %b we %b be %h addr %0d wdata %h expected 00 0 0 0 7 12345678",
                         o_gnt, o_en, o_we, o_be, o_addr, o_wdata);
    end
    n_asserts++;
    if (o_rvalid !== 2'b00) begin n_fail++; $display("FAIL idle_rvalid: got %b expected 00", o_rvalid); end
    we[0] = 1'b0;
  endtask

  task automatic test_contention();
    logic [1:0] order [4];
    order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
    do_reset();
    req = 2'b11; we = 2'b00; addr[0] = 13'd1; addr[1] = 13'd2;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{(order[i] == 2'b10) ? 1 : 0, 1'b0, 32'h0});
      tick();
      n_asserts++;
      if (o_gnt !== order[i] || o_addr !== ((order[i] == 2'b10) ? 13'd2 : 13'd1)) begin
        n_fail++; $display("FAIL cont_gnt[%0d]: gnt %b addr %0d expected %b", i, o_gnt, o_addr, order[i]);
      end
      rsp = exp_q.pop_front();
      n_asserts++;
      if (o_rvalid !== (2'b01 << rsp.port)) begin
        n_fail++; $display("FAIL cont_rvalid[%0d]: got %b expected %b", i, o_rvalid, 2'(2'b01 << rsp.port));
      end
    end
    n_asserts++;
    if (o_cnt !== 16'd4) begin n_fail++; $display("FAIL cont_cnt: got %0d expected 4", o_cnt); end
    req = 2'b00;
  endtask

  task automatic test_byte_write();
    req = 2'b10; addr[1] = 13'd9; we[1] = 1'b1; be[1] = 4'hF; wdata[1] = 32'h11223344;
    exp_q.push_back('{1, 1'b0, 32'h0});
    tick();
    rsp = exp_q.pop_front();
    n_asserts++;
    if (o_gnt !== 2'b10 || o_rvalid !== (2'b01 << rsp.port)) begin
      n_fail++; $display("FAIL bw_init: gnt %b rvalid %b expected 10 10", o_gnt, o_rvalid);
    end
    be[1] = 4'b0010; wdata[1] = 32'h0000AB00;
    exp_q.push_back('{1, 1'b0, 32'h0});
    tick();
    rsp = exp_q.pop_front();
    n_asserts++;
    if (o_be !== 4'b0010 || o_wdata !== 32'h0000AB00 || o_rvalid !== (2'b01 << rsp.port)) begin
      n_fail++; $display("FAIL bw_write: be %b wdata %h rvalid %b expected 0010 0000ab00 10", o_be, o_wdata, o_rvalid);
    end
    we[1] = 1'b0; be[1] = 4'h1;
    exp_q.push_back('{1, 1'b1, 32'h1122AB44});
    tick();
    rsp = exp_q.pop_front();
    n_asserts++;
    if (o_rvalid !== (2'b01 << rsp.port) || o_rdata[rsp.port] !== rsp.data) begin
      n_fail++; $display("FAIL bw_read: rvalid %b rdata %h expected 10 %h", o_rvalid, o_rdata[rsp.port], rsp.data);
    end
    req = 2'b00;
  endtask

  task automatic test_fixed_prio();
    do_reset();
    fp_req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_asserts++;
      if (o_fp_gnt !== 2'b01) begin n_fail++; $display("FAIL fp_gnt[%0d]: got %b expected 01", i, o_fp_gnt); end
    end
    fp_req = 2'b10;
    tick();
    n_asserts++;
    if (o_fp_gnt !== 2'b10 || o_fp_rvalid !== 2'b10) begin
      n_fail++; $display("FAIL fp_port1: gnt %b rvalid %b expected 10 10", o_fp_gnt, o_fp_rvalid);
    end
    fp_req = 2'b00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 2'b11; we = 2'b00;
    repeat (2) tick();
    req = 2'b10;
    tick();
    n_asserts++;
    if (o_gnt !== 2'b10 || o_cnt !== 16'd2) begin
      n_fail++; $display("FAIL rm_pre: gnt %b cnt %0d expected 10 2", o_gnt, o_cnt);
    end
    rst_n = 1'b0; req = 2'b11;
    #1;
    n_asserts++;
    if (rvalid !== 2'b00 || cnt !== 16'd0) begin
      n_fail++; $display("FAIL rm_async: rvalid %b cnt %0d expected 00 0", rvalid, cnt);
    end
    @(posedge clk); #1;
    n_asserts++;
    if (rvalid !== 2'b00 || gnt !== 2'b00 || en !== 1'b0) begin
      n_fail++; $display("FAIL rm_hold: rvalid %b gnt %b en %b expected 00 00 0", rvalid, gnt, en);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; req = 2'b00;
    tick();
    n_asserts++;
    if (o_rvalid !== 2'b00 || o_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rm_release: rvalid %b cnt %0d expected 00 0", o_rvalid, o_cnt);
    end
    req = 2'b11;
    tick();
    n_asserts++;
    if (o_gnt !== 2'b01 || o_rvalid !== 2'b01 || o_cnt !== 16'd1) begin
      n_fail++; $display("FAIL rm_first: gnt %b rvalid %b cnt %0d expected 01 01 1", o_gnt, o_rvalid, o_cnt);
    end
    req = 2'b00;
  endtask

  task automatic test_saturation();
    do_reset();
    req = 2'b11; we = 2'b00;
    repeat (65533) tick();
    n_asserts++;
    if (o_cnt !== 16'hFFFD) begin n_fail++; $display("FAIL sat_pre: got %h expected fffd", o_cnt); end
    repeat (2) tick();
    n_asserts++;
    if (o_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach: got %h expected ffff", o_cnt); end
    repeat (2) tick();
    n_asserts++;
    if (o_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h expected ffff", o_cnt); end
    clr = 1'b1;
    tick();
    n_asserts++;
    if (o_cnt !== 16'h0000) begin n_fail++; $display("FAIL clr_prio: got %h expected 0000", o_cnt); end
    clr = 1'b0;
    tick();
    n_asserts++;
    if (o_cnt !== 16'h0001) begin n_fail++; $display("FAIL clr_resume: got %h expected 0001", o_cnt); end
    req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_byte_write();
    test_fixed_prio();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
